// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-port (AVR / SNES) arbiter driving an asynchronous SRAM
//            through IDLE -> SETUP -> STROBE -> RECOVER access cycles.
// Options  : SRAM_ARB_RR_EN - round-robin tie break instead of SNES priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        avr_clk,
    input  logic        avr_reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [20:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic [7:0]  a_rdata,
    output logic        a_ack,
    input  logic        s_req,
    input  logic        s_we,
    input  logic [20:0] s_addr,
    input  logic [7:0]  s_wdata,
    output logic [7:0]  s_rdata,
    output logic        s_ack,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_en,
    input  logic [7:0]  sram_din,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy,
    output logic        grant
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_setup   = 2'd1;
    localparam logic [1:0] c_st_strobe  = 2'd2;
    localparam logic [1:0] c_st_recover = 2'd3;
    localparam logic [2:0] c_strobe_last = 3'(ACCESS_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic       r_we;
    logic [7:0] r_wdata;
    logic       w_pick_snes;

`ifdef SRAM_ARB_RR_EN
    // On a tie the port that did not own the previous access wins.
    assign w_pick_snes = s_req && (!a_req || !grant);
`else
    assign w_pick_snes = s_req;
`endif

    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= 3'd0;
            r_we         <= 1'b0;
            r_wdata      <= 8'd0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_dout_en <= 1'b0;
            sram_addr    <= 21'd0;
            sram_dout    <= 8'd0;
            a_ack        <= 1'b0;
            s_ack        <= 1'b0;
            a_rdata      <= 8'd0;
            s_rdata      <= 8'd0;
            busy         <= 1'b0;
            grant        <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            s_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (a_req || s_req) begin
                        grant        <= w_pick_snes;
                        r_we         <= w_pick_snes ? s_we    : a_we;
                        r_wdata      <= w_pick_snes ? s_wdata : a_wdata;
                        sram_addr    <= w_pick_snes ? s_addr  : a_addr;
                        sram_dout_en <= w_pick_snes ? s_we    : a_we;
                        sram_ce_n    <= 1'b0;
                        sram_oe_n    <= 1'b1;
                        sram_we_n    <= 1'b1;
                        busy         <= 1'b1;
                        r_cnt        <= 3'd0;
                        r_state      <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    if (r_we) begin
                        sram_we_n    <= 1'b0;
                        sram_dout    <= r_wdata;
                        sram_dout_en <= 1'b1;
                    end else begin
                        sram_oe_n <= 1'b0;
                    end
                    r_state <= c_st_strobe;
                end
                c_st_strobe: begin
                    if (r_cnt == c_strobe_last) begin
                        r_cnt     <= 3'd0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        // Read data is sampled on the same edge the strobe rises.
                        if (!r_we) begin
                            if (grant) s_rdata <= sram_din;
                            else       a_rdata <= sram_din;
                        end
                        if (grant) s_ack <= 1'b1;
                        else       a_ack <= 1'b1;
                        r_state <= c_st_recover;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_st_recover: begin
                    busy         <= 1'b0;
                    sram_dout_en <= 1'b0;
                    r_state      <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SHALL set the number of cycles the SRAM strobe is held low (legal range 1..7).
REQ-002 avr_clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 avr_reset  in  1  synchronous, active-high reset.
REQ-004 a_req, a_we  in  1 each  AVR port: request held until ack; we=1 write, we=0 read.
REQ-005 a_addr  in  21, a_wdata  in  8, a_rdata  out  8, a_ack  out  1  AVR port address, write data, read data, completion pulse.
REQ-006 s_req, s_we  in  1 each; s_addr  in  21; s_wdata  in  8; s_rdata  out  8; s_ack  out  1  SNES port, same meanings as the AVR port.
REQ-007 sram_addr  out  21; sram_dout  out  8; sram_dout_en  out  1; sram_din  in  8  SRAM address, write data, write-data drive enable, read data.
REQ-008 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-009 busy  out  1  high in every state except IDLE; grant  out  1  owner of the current or last access (0=AVR, 1=SNES).

Function
REQ-010 FSM states SHALL be IDLE, SETUP, STROBE and RECOVER.
REQ-011 IDLE: if either req is high at the edge, latch the winner's addr/we/wdata and move to SETUP; otherwise stay in IDLE.
REQ-012 Tie (both req high in IDLE): SNES SHALL win.
REQ-013 SETUP (1 cycle): sram_addr = latched address, ce_n=0, oe_n=1, we_n=1, dout_en = latched we.
REQ-014 STROBE (ACCESS_CYCLES cycles, counted by a 3-bit counter): read -> oe_n=0; write -> we_n=0 with dout_en=1 and sram_dout = latched wdata.
REQ-015 On the last STROBE edge, a read SHALL capture sram_din into the owner's rdata register.
REQ-016 RECOVER (1 cycle): ce_n=oe_n=we_n=1; dout_en stays at the latched we (write data hold); the owner's ack SHALL be high for exactly this cycle; next state is IDLE.
REQ-017 Latency: ack SHALL be high in cycle ACCESS_CYCLES+2 after the IDLE edge that sampled req (cycle 4 for the default).
REQ-018 A requester SHALL hold req, addr, we and wdata stable until it sees ack and drop req by the following edge; because of RECOVER, a req still high when IDLE is re-entered is treated as a new request.
REQ-019 a_rdata and s_rdata SHALL hold their last captured value until that port's next read completes; writes SHALL NOT alter them.
REQ-020 Request inputs changing outside IDLE SHALL NOT affect the access in progress.
REQ-021 The non-owner's ack SHALL remain 0 in all states.
REQ-022 Outside IDLE, sram_addr SHALL hold the latched address; in IDLE it holds its last value.

Reset
REQ-023 While avr_reset is high at an edge, the block SHALL force:
- state=IDLE, counter=0
- sram_ce_n=sram_oe_n=sram_we_n=1
- sram_dout_en=0, sram_addr=0, sram_dout=0
- a_ack=s_ack=0, a_rdata=s_rdata=0
- busy=0, grant=0
REQ-024 Reset during SETUP, STROBE or RECOVER SHALL abort the access with no ack, and the strobes SHALL be high from the next edge onward.

Configuration
REQ-025 With macro SRAM_ARB_RR_EN defined, ties SHALL go to the port not granted last (round-robin via grant); without it, ties SHALL go to SNES (REQ-012).

Verification
REQ-026 AVR read, ACCESS_CYCLES=2: a_req=1, a_we=0, a_addr=21'h012345, sram_din=8'hAA -> oe_n low for 2 cycles; a_ack high in cycle 4; a_rdata=8'hAA.
REQ-027 SNES write: s_addr=21'h1FFFFF, s_wdata=8'hEE -> we_n low for 2 cycles with sram_dout=8'hEE and dout_en=1 through RECOVER; s_ack pulses once; s_rdata unchanged.
REQ-028 Both req high together, repeated 4 times:
- without SRAM_ARB_RR_EN -> grant sequence 1,1,1,1
- with SRAM_ARB_RR_EN -> grant sequence 1,0,1,0
REQ-029 avr_reset asserted during the first STROBE cycle of an AVR write -> we_n=1 and dout_en=0 on the next edge; no a_ack; state IDLE.
REQ-030 a_req held high across ack -> a second access starts only after RECOVER; exactly one ack per 4-cycle access.
REQ-031 ACCESS_CYCLES=7 read -> oe_n low for exactly 7 cycles; ack in cycle 9.
